sd2_dac_feeder: RTL and testbench

- Stereo sample scheduler in front of the two-channel second-order sigma-delta DAC.
- Accepts samples from a sound core through a valid/ready handshake and buffers them in a small FIFO.
- Presents one sample pair to the DAC data inputs every PERIOD clocks, aligned to the DAC's 16-clock linear-interpolation rate.
- Handles FIFO priming, underrun hold and a click-free linear mute ramp.

---
 rtl/sd2_dac_feeder.sv | 199 +++++++++++++++++++
 tb/tb_sd2_dac_feeder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd2_dac_feeder.sv
// Stereo sample scheduler for the two-channel sigma-delta DAC: buffers producer
// sample pairs and releases one pair every PERIOD clocks, with priming, underrun hold and mute ramp.
module sd2_dac_feeder #(
  parameter int DW         = 16,
  parameter int DEPTH_LOG2 = 2,
  parameter int PERIOD     = 16,
  parameter int STEP       = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mute,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_left,
  input  logic [DW-1:0]         in_right,
  output logic [DW-1:0]         ldatasum,
  output logic [DW-1:0]         rdatasum,
  output logic                  sample_tick,
  output logic                  underrun,
  input  logic                  underrun_clr,
  output logic [DEPTH_LOG2:0]   fill,
  output logic [1:0]            state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  localparam logic [CW-1:0]         CNT_MAX    = CW'(PERIOD - 1);
  localparam logic [DEPTH_LOG2:0]   FILL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   FILL_PRIME = (DEPTH_LOG2 + 1)'(DEPTH / 2);
  localparam logic signed [DW:0]    STEP_W     = (DW + 1)'(STEP);

  localparam logic [1:0] ST_PRIME  = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_MUTING = 2'd2;
  localparam logic [1:0] ST_MUTED  = 2'd3;

  // One ramp step toward zero; the extra bit keeps -2^(DW-1)+STEP from wrapping.
  function automatic logic [DW-1:0] ramp_step(input logic [DW-1:0] x);
    logic signed [DW:0] xe;
    logic signed [DW:0] r;
    xe = signed'({x[DW-1], x});
    if (xe > STEP_W) begin
      r = xe - STEP_W;
    end else if (xe < -STEP_W) begin
      r = xe + STEP_W;
    end else begin
      r = '0;
    end
    return r[DW-1:0];
  endfunction

  logic [CW-1:0]          cnt;
  logic                   tick;
  logic [2*DW-1:0]        mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [2*DW-1:0]        head;
  logic                   push;
  logic                   pop;
  logic                   set_underrun;
  logic [1:0]             nxt_state;
  logic [DW-1:0]          nxt_l;
  logic [DW-1:0]          nxt_r;
  logic [DW-1:0]          ramp_l;
  logic [DW-1:0]          ramp_r;

  assign tick     = (cnt == CNT_MAX);
  assign in_ready = (fill < FILL_FULL);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign ramp_l   = ramp_step(ldatasum);
  assign ramp_r   = ramp_step(rdatasum);

  // Sample-rate divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Scheduler: decides pops, output loads and state moves on each tick.
  always_comb begin
    pop          = 1'b0;
    set_underrun = 1'b0;
    nxt_state    = state;
    nxt_l        = ldatasum;
    nxt_r        = rdatasum;
    if (tick) begin
      case (state)
        ST_PRIME: begin
          if (mute) begin
            nxt_state = ST_MUTING;
          end else if (fill >= FILL_PRIME) begin
            pop       = 1'b1;
            nxt_l     = head[2*DW-1:DW];
            nxt_r     = head[DW-1:0];
            nxt_state = ST_RUN;
          end else begin
            nxt_state = ST_PRIME;
          end
        end
        ST_RUN: begin
          if (mute) begin
            nxt_state = ST_MUTING;
          end else if (fill != '0) begin
            pop   = 1'b1;
            nxt_l = head[2*DW-1:DW];
            nxt_r = head[DW-1:0];
          end else begin
            set_underrun = 1'b1;
            nxt_state    = ST_PRIME;
          end
        end
        ST_MUTING: begin
          nxt_l = ramp_l;
          nxt_r = ramp_r;
          pop   = (fill != '0);
          if ((ramp_l == '0) && (ramp_r == '0)) begin
            nxt_state = ST_MUTED;
          end else begin
            nxt_state = ST_MUTING;
          end
        end
        ST_MUTED: begin
          nxt_l = '0;
          nxt_r = '0;
          pop   = (fill != '0);
          if (!mute) begin
            nxt_state = ST_PRIME;
          end else begin
            nxt_state = ST_MUTED;
          end
        end
        default: begin
          nxt_state = ST_PRIME;
        end
      endcase
    end else begin
      nxt_state = state;
    end
  end

  // FIFO storage; contents need no reset since fill gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_left, in_right};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({push, pop})
        2'b10:   fill <= fill + (DEPTH_LOG2 + 1)'(1);
        2'b01:   fill <= fill - (DEPTH_LOG2 + 1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Output registers, state and sticky underrun (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ldatasum    <= '0;
      rdatasum    <= '0;
      sample_tick <= 1'b0;
      state       <= ST_PRIME;
      underrun    <= 1'b0;
    end else begin
      ldatasum    <= nxt_l;
      rdatasum    <= nxt_r;
      sample_tick <= tick;
      state       <= nxt_state;
      if (set_underrun) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end else begin
        underrun <= underrun;
      end
    end
  end

endmodule

// File: tb/tb_sd2_dac_feeder.sv
// Self-checking bench for sd2_dac_feeder: scoreboard for loaded pairs, a vector
// table for mute-ramp steps, and hand sequences for priming, backpressure, underrun and reset.
module tb_sd2_dac_feeder;

  localparam int DW     = 16;
  localparam int PERIOD = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mute = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_left = '0;
  logic [DW-1:0] in_right = '0;
  logic [DW-1:0] ldatasum;
  logic [DW-1:0] rdatasum;
  logic          sample_tick;
  logic          underrun;
  logic          underrun_clr = 1'b0;
  logic [2:0]    fill;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;
  logic [2*DW-1:0] sbq[$];

  typedef struct {
    logic [DW-1:0] l, r, l1, r1, l2, r2;
    logic [1:0]    s1, s2;
  } vec_t;
  vec_t vecs[5];

  sd2_dac_feeder dut (
    .clk(clk), .rst(rst), .mute(mute), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .ldatasum(ldatasum), .rdatasum(rdatasum),
    .sample_tick(sample_tick), .underrun(underrun), .underrun_clr(underrun_clr),
    .fill(fill), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every load seen in RUN must match the oldest scoreboarded pair.
  always @(negedge clk) begin
    if (!rst && sample_tick && state == 2'd1) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_load", {ldatasum, rdatasum}, 32'hDEAD_BEEF);
      end else begin
        check("sb_data", {ldatasum, rdatasum}, sbq.pop_front());
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    mute = 1'b0;
    in_valid = 1'b0;
    underrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    sbq.delete();
    rst = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit sb);
    bit ok = 1'b0;
    in_left = l;
    in_right = r;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) check("push_timeout", 32'd0, 32'd1);
    else if (sb) sbq.push_back({l, r});
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      @(negedge clk);
      if (sample_tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("tick_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int seen_at[$];
    int el, er;

    vecs[0] = '{16'h0300, 16'h8000, 16'h0200, 16'h8100, 16'h0100, 16'h8200, 2'd2, 2'd2};
    vecs[1] = '{16'h0100, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd3, 2'd3};
    vecs[2] = '{16'h7FFF, 16'h0000, 16'h7EFF, 16'h0000, 16'h7DFF, 16'h0000, 2'd2, 2'd2};
    vecs[3] = '{16'h0101, 16'hFEFF, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 2'd2, 2'd3};
    vecs[4] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd3, 2'd3};

    // Reset state and tick cadence.
    apply_reset();
    check("rst_l", ldatasum, 32'h0);
    check("rst_r", rdatasum, 32'h0);
    check("rst_state", state, 32'd0);
    check("rst_ready", in_ready, 32'd1);
    check("rst_fill", fill, 32'd0);
    check("rst_underrun", underrun, 32'd0);
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (sample_tick) seen_at.push_back(k);
    end
    check("tick_count", seen_at.size(), 32'd3);
    for (int i = 0; i < seen_at.size(); i++) check("tick_pos", seen_at[i], 32'(16 * (i + 1)));

    // Priming and first two loads.
    push(16'h1000, 16'hF000, 1'b1);
    push(16'h2000, 16'hE000, 1'b1);
    wait_tick();
    check("prime_state", state, 32'd1);
    check("prime_l", ldatasum, 32'h1000);
    check("prime_r", rdatasum, 32'hF000);
    check("prime_fill", fill, 32'd1);
    wait_tick();
    check("run2_l", ldatasum, 32'h2000);
    check("run2_r", rdatasum, 32'hE000);
    check("run2_fill", fill, 32'd0);

    // Underrun hold and clear.
    wait_tick();
    check("ur_l", ldatasum, 32'h2000);
    check("ur_r", rdatasum, 32'hE000);
    check("ur_flag", underrun, 32'd1);
    check("ur_state", state, 32'd0);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("ur_clr", underrun, 32'd0);

    // Backpressure: five pairs into a four-deep FIFO.
    for (int i = 0; i < 4; i++) push(16'(16'h0100 * (i + 1)), 16'(16'h0011 * (i + 1)), 1'b1);
    check("full_fill", fill, 32'd4);
    check("full_ready", in_ready, 32'd0);
    push(16'h0500, 16'h0055, 1'b1);
    check("fifth_fill", fill, 32'd4);
    check("fifth_state", state, 32'd1);
    repeat (4) wait_tick();
    check("drain_fill", fill, 32'd0);
    wait_tick();
    check("drain_ur", underrun, 32'd1);
    check("drain_state", state, 32'd0);

    // Table-driven ramp steps.
    for (int v = 0; v < 5; v++) begin
      apply_reset();
      push(vecs[v].l, vecs[v].r, 1'b1);
      push(vecs[v].l, vecs[v].r, 1'b0);
      wait_tick();
      check("vec_run", state, 32'd1);
      mute = 1'b1;
      wait_tick();
      check("vec_enter", state, 32'd2);
      check("vec_hold", {ldatasum, rdatasum}, {vecs[v].l, vecs[v].r});
      wait_tick();
      check("vec_step1", {ldatasum, rdatasum}, {vecs[v].l1, vecs[v].r1});
      check("vec_state1", state, 32'(vecs[v].s1));
      wait_tick();
      check("vec_step2", {ldatasum, rdatasum}, {vecs[v].l2, vecs[v].r2});
      check("vec_state2", state, 32'(vecs[v].s2));
      mute = 1'b0;
    end

    // Full ramp from (0x0300, 0x8000) with a 3-deep backlog, then release.
    apply_reset();
    push(16'h0300, 16'h8000, 1'b1);
    push(16'h0300, 16'h8000, 1'b0);
    wait_tick();
    push(16'h0AAA, 16'h0BBB, 1'b0);
    push(16'h0CCC, 16'h0DDD, 1'b0);
    check("ramp_fill3", fill, 32'd3);
    mute = 1'b1;
    wait_tick();
    for (int i = 1; i <= 128; i++) begin
      wait_tick();
      el = (16'h0300 > 256 * i) ? (16'h0300 - 256 * i) : 0;
      er = -32768 + 256 * i;
      check("ramp_out", {ldatasum, rdatasum}, {16'(el), 16'(er)});
      check("ramp_state", state, (i < 128) ? 32'd2 : 32'd3);
      if (i == 3) check("ramp_drain", fill, 32'd0);
    end
    check("ramp_no_ur", underrun, 32'd0);
    mute = 1'b0;
    wait_tick();
    check("unmute_state", state, 32'd0);
    check("unmute_out", {ldatasum, rdatasum}, 32'h0);
    push(16'h1234, 16'h5678, 1'b1);
    push(16'h0ABC, 16'hF123, 1'b1);
    wait_tick();
    check("unmute_run", state, 32'd1);
    wait_tick();
    check("unmute_run2", state, 32'd1);

    // Asynchronous reset in the middle of a ramp.
    apply_reset();
    push(16'h0300, 16'h8000, 1'b1);
    push(16'h0300, 16'h8000, 1'b0);
    wait_tick();
    mute = 1'b1;
    wait_tick();
    wait_tick();
    check("mid_pre", ldatasum, 32'h0200);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out", {ldatasum, rdatasum}, 32'h0);
    check("mid_rst_state", state, 32'd0);
    check("mid_rst_fill", fill, 32'd0);
    apply_reset();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
